nor_rd_stream: RTL

- Upstream master for the NOR memory wishbone port (memwb_*).
- Accepts a burst-read command (start word address and word count) and issues pipelined single-word read requests, with cyc held for the whole burst.
- Collects acked data into an internal FIFO and presents it on a valid/ready stream for the downstream bridge/packetiser.
- Credit-limits outstanding requests so that read data is never dropped.

---
 rtl/nor_rd_stream_if.sv | 25 ++
 rtl/nor_rd_stream.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/nor_rd_stream_if.sv
// Wishbone pipelined read-master bus between the burst reader and the NOR port.
interface nor_rd_stream_if #(
    parameter int ADDRBITS = 26,
    parameter int DATABITS = 16
);
    logic                cyc;
    logic                stb;
    logic                we;
    logic [ADDRBITS-1:0] adr;
    logic [DATABITS-1:0] dat_w;
    logic                stall;
    logic                ack;
    logic                err;
    logic [DATABITS-1:0] dat_r;

    modport master (
        output cyc, stb, we, adr, dat_w,
        input  stall, ack, err, dat_r
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w,
        output stall, ack, err, dat_r
    );
endinterface

// File: rtl/nor_rd_stream.sv
// Burst reader for the NOR wishbone port: issues pipelined single-word reads,
// buffers acked words in a small FIFO and streams them out with a last marker.
// Requests are credit-limited so every outstanding read has a FIFO slot.
module nor_rd_stream #(
    parameter int ADDRBITS  = 26,
    parameter int DATABITS  = 16,
    parameter int COUNTBITS = 16,
    parameter int FIFODEPTH = 4
) (
    input  logic                 sys_clk_i,
    input  logic                 sys_rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [ADDRBITS-1:0]  cmd_addr_i,
    input  logic [COUNTBITS-1:0] cmd_count_i,
    input  logic                 abort_i,
    output logic                 done_o,
    output logic                 err_o,
    nor_rd_stream_if.master      memwb,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DATABITS-1:0]  out_data_o,
    output logic                 out_last_o
);
    localparam int PTRW = (FIFODEPTH > 1) ? $clog2(FIFODEPTH) : 1;
    localparam int CNTW = PTRW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIN} state_t;

    state_t               state_q, state_d;
    logic [ADDRBITS-1:0]  adr_q, adr_d;
    logic [COUNTBITS-1:0] issue_q, issue_d;   // requests still to be accepted
    logic [COUNTBITS-1:0] recv_q, recv_d;     // words still to be received
    logic [CNTW-1:0]      outst_q, outst_d;   // accepted but not yet acked
    logic                 err_q, err_d;

    logic [DATABITS:0]    fifo_mem [FIFODEPTH];
    logic [PTRW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0]      fcnt_q, fcnt_d;

    logic                 busy;
    logic                 credit_ok;
    logic [CNTW:0]        credit_used;
    logic                 stb;
    logic                 accept;
    logic                 bus_err;
    logic                 bus_abort;
    logic                 kill;
    logic                 ack_ok;
    logic                 pop;
    logic                 cmd_acc;

    assign busy        = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    // Credit uses registered counts only; an ack moves a word from
    // outstanding to the FIFO, so the sum changes only by our issue or a pop.
    assign credit_used = {1'b0, outst_q} + {1'b0, fcnt_q};
    assign credit_ok   = credit_used < (CNTW+1)'(FIFODEPTH);
    assign stb         = (state_q == S_ISSUE) && credit_ok;
    assign accept      = stb && !memwb.stall;
    assign bus_err     = busy && memwb.err;
    assign bus_abort   = busy && abort_i;
    assign kill        = bus_err || bus_abort;
    assign ack_ok      = busy && memwb.ack && (outst_q != '0) && !kill;
    assign pop         = out_valid_o && out_ready_i;
    assign cmd_acc     = cmd_valid_i && cmd_ready_o;

    assign cmd_ready_o = (state_q == S_IDLE);
    assign done_o      = (state_q == S_FIN);
    assign err_o       = err_q;

    assign memwb.cyc   = busy;
    assign memwb.stb   = stb;
    assign memwb.we    = 1'b0;
    assign memwb.adr   = adr_q;
    assign memwb.dat_w = '0;

    assign out_valid_o = (fcnt_q != '0);
    assign out_data_o  = fifo_mem[rd_ptr_q][DATABITS-1:0];
    assign out_last_o  = out_valid_o && fifo_mem[rd_ptr_q][DATABITS];

    // Next-state and counter updates; error/abort override everything.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        issue_d = issue_q;
        recv_d  = recv_q;
        err_d   = err_q;
        outst_d = outst_q + CNTW'(accept) - CNTW'(ack_ok);
        if (ack_ok) begin
            recv_d = recv_q - COUNTBITS'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (cmd_acc) begin
                    adr_d   = cmd_addr_i;
                    issue_d = cmd_count_i;
                    recv_d  = cmd_count_i;
                    err_d   = 1'b0;
                    state_d = (cmd_count_i == '0) ? S_FIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (accept) begin
                    adr_d   = adr_q + ADDRBITS'(1);
                    issue_d = issue_q - COUNTBITS'(1);
                    if (issue_q == COUNTBITS'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (outst_d == '0) begin
                    state_d = S_FIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (kill) begin
            state_d = S_FIN;
            outst_d = '0;
            if (bus_err) begin
                err_d = 1'b1;
            end
        end
    end

    // FIFO occupancy: an ack and a pop in the same cycle cancel out.
    always_comb begin
        fcnt_d = fcnt_q + CNTW'(ack_ok) - CNTW'(pop);
    end

    // Control state registers.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q <= S_IDLE;
            adr_q   <= '0;
            issue_q <= '0;
            recv_q  <= '0;
            outst_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            issue_q <= issue_d;
            recv_q  <= recv_d;
            outst_q <= outst_d;
            err_q   <= err_d;
        end
    end

    // FIFO pointers and count; abort discards every buffered word at once.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i || bus_abort) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
        end else begin
            if (ack_ok) begin
                wr_ptr_q <= wr_ptr_q + PTRW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTRW'(1);
            end
            fcnt_q <= fcnt_d;
        end
    end

    // FIFO storage; the last flag rides with the word that completes the count.
    always_ff @(posedge sys_clk_i) begin
        if (ack_ok) begin
            fifo_mem[wr_ptr_q] <= {(recv_q == COUNTBITS'(1)), memwb.dat_r};
        end
    end
endmodule
